// File: rtl/sram_port_arb_if.sv
// Bundles the two requester ports, the SRAM pins and the grant counters of sram_port_arb.
// The slave modport is the arbiter's view; master is the requester/SRAM-side view.
interface sram_port_arb_if #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 32
);
   localparam int BW = DWIDTH / 8;

   logic              i_mode;
   logic              i_req0;
   logic [AWIDTH-1:0] i_addr0;
   logic              o_gnt0;
   logic              o_rvalid0;
   logic [DWIDTH-1:0] o_rdata0;
   logic              i_req1;
   logic              i_we1;
   logic [BW-1:0]     i_be1;
   logic [AWIDTH-1:0] i_addr1;
   logic [DWIDTH-1:0] i_wdata1;
   logic              o_gnt1;
   logic              o_rvalid1;
   logic [DWIDTH-1:0] o_rdata1;
   logic              o_memCsn;
   logic              o_memWen;
   logic [BW-1:0]     o_memBe;
   logic [AWIDTH-1:0] o_memAddr;
   logic [DWIDTH-1:0] o_memDi;
   logic [DWIDTH-1:0] i_memDout;
   logic [31:0]       o_gcnt0;
   logic [31:0]       o_gcnt1;

   modport slave (
      input  i_mode, i_req0, i_addr0, i_req1, i_we1, i_be1, i_addr1, i_wdata1, i_memDout,
      output o_gnt0, o_rvalid0, o_rdata0, o_gnt1, o_rvalid1, o_rdata1,
             o_memCsn, o_memWen, o_memBe, o_memAddr, o_memDi, o_gcnt0, o_gcnt1
   );

   modport master (
      output i_mode, i_req0, i_addr0, i_req1, i_we1, i_be1, i_addr1, i_wdata1, i_memDout,
      input  o_gnt0, o_rvalid0, o_rdata0, o_gnt1, o_rvalid1, o_rdata1,
             o_memCsn, o_memWen, o_memBe, o_memAddr, o_memDi, o_gcnt0, o_gcnt1
   );
endinterface

// File: rtl/sram_port_arb.sv
// Two-port arbiter in front of a single-port synchronous SRAM: port 0 fetches, port 1 reads/writes.
// Grants are combinational; read data returns one cycle later, tagged with the port that asked.
module sram_port_arb #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 32
) (
   input logic             i_clk,
   input logic             i_rst,
   sram_port_arb_if.slave  bus
);
   localparam int BW = DWIDTH / 8;

   logic              r_lastGnt;
   logic              r_tagValid;
   logic              r_tagPort;
   logic [31:0]       r_gcnt0;
   logic [31:0]       r_gcnt1;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_rvalid0;
   logic              w_rvalid1;
   logic              w_memCsn;
   logic              w_memWen;
   logic [BW-1:0]     w_memBe;
   logic [AWIDTH-1:0] w_memAddr;
   logic [DWIDTH-1:0] w_memDi;

   // On a tie, round-robin favours whichever port did not win last (r_lastGnt=1 means port 1 won).
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!i_rst) begin
         w_gnt0 = bus.i_req0 && (!bus.i_req1 || (!bus.i_mode && r_lastGnt));
         w_gnt1 = bus.i_req1 && (!bus.i_req0 || bus.i_mode || !r_lastGnt);
      end
   end

   always_comb begin
      w_memCsn  = 1'b1;
      w_memWen  = 1'b1;
      w_memBe   = '0;
      w_memAddr = '0;
      w_memDi   = '0;
      if (w_gnt0) begin
         w_memCsn  = 1'b0;
         w_memBe   = '1;
         w_memAddr = bus.i_addr0;
      end else if (w_gnt1) begin
         w_memCsn  = 1'b0;
         w_memWen  = !bus.i_we1;
         w_memBe   = bus.i_be1;
         w_memAddr = bus.i_addr1;
         w_memDi   = bus.i_wdata1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lastGnt  <= 1'b1;
         r_tagValid <= 1'b0;
         r_tagPort  <= 1'b0;
         r_gcnt0    <= '0;
         r_gcnt1    <= '0;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_lastGnt <= w_gnt1;
         end
         r_tagValid <= w_gnt0 || (w_gnt1 && !bus.i_we1);
         r_tagPort  <= w_gnt1;
         if (w_gnt0 && (r_gcnt0 != 32'hFFFF_FFFF)) begin
            r_gcnt0 <= r_gcnt0 + 32'd1;
         end
         if (w_gnt1 && (r_gcnt1 != 32'hFFFF_FFFF)) begin
            r_gcnt1 <= r_gcnt1 + 32'd1;
         end
      end
   end

   // Reset held in the return cycle kills the pending read response.
   assign w_rvalid0 = r_tagValid && !r_tagPort && !i_rst;
   assign w_rvalid1 = r_tagValid && r_tagPort && !i_rst;

   assign bus.o_gnt0    = w_gnt0;
   assign bus.o_gnt1    = w_gnt1;
   assign bus.o_rvalid0 = w_rvalid0;
   assign bus.o_rvalid1 = w_rvalid1;
   assign bus.o_rdata0  = w_rvalid0 ? bus.i_memDout : '0;
   assign bus.o_rdata1  = w_rvalid1 ? bus.i_memDout : '0;
   assign bus.o_memCsn  = w_memCsn;
   assign bus.o_memWen  = w_memWen;
   assign bus.o_memBe   = w_memBe;
   assign bus.o_memAddr = w_memAddr;
   assign bus.o_memDi   = w_memDi;
   assign bus.o_gcnt0   = r_gcnt0;
   assign bus.o_gcnt1   = r_gcnt1;
endmodule

// File: tb/tb_sram_port_arb.sv
// Directed and random checks of sram_port_arb against a transaction-level model of the
// arbitration rules, with a behavioural SRAM attached to the memory pins.
module tb_sram_port_arb;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   sram_port_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   sram_port_arb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: one-cycle read latency, byte-masked writes
   logic [DW-1:0] sram [0:DEPTH-1];
   always @(posedge clk) begin
      if (!bus.o_memCsn) begin
         if (bus.o_memWen) begin
            bus.i_memDout <= sram[bus.o_memAddr];
         end else begin
            for (int b = 0; b < DW / 8; b++) begin
               if (bus.o_memBe[b]) sram[bus.o_memAddr][b*8 +: 8] <= bus.o_memDi[b*8 +: 8];
            end
         end
      end
   end

   // Reference model state: who won last, grant totals, pending read response, memory image
   int            modLast;
   logic [31:0]   modCnt0;
   logic [31:0]   modCnt1;
   bit            modPend;
   int            modPendPort;
   logic [DW-1:0] modPendData;
   logic [DW-1:0] refMem [0:DEPTH-1];
   bit            expG0;
   bit            expG1;

   // Watchdog so the bench always ends
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Predict every output for the current cycle from the arbitration rules and compare
   task automatic checkOutput();
      logic [DW-1:0] expRd0;
      logic [DW-1:0] expRd1;
      bit            expRv0;
      bit            expRv1;
      expG0 = 0;
      expG1 = 0;
      if (!rst) begin
         if (bus.i_req0 && !bus.i_req1) expG0 = 1;
         else if (bus.i_req1 && !bus.i_req0) expG1 = 1;
         else if (bus.i_req0 && bus.i_req1) begin
            if (bus.i_mode) expG1 = 1;
            else if (modLast == 1) expG0 = 1;
            else expG1 = 1;
         end
      end
      expRv0 = modPend && (modPendPort == 0) && !rst;
      expRv1 = modPend && (modPendPort == 1) && !rst;
      expRd0 = expRv0 ? modPendData : '0;
      expRd1 = expRv1 ? modPendData : '0;

      checkVal("gnt0", {31'd0, bus.o_gnt0}, {31'd0, expG0});
      checkVal("gnt1", {31'd0, bus.o_gnt1}, {31'd0, expG1});
      checkVal("memCsn", {31'd0, bus.o_memCsn}, {31'd0, !(expG0 || expG1)});
      checkVal("memWen", {31'd0, bus.o_memWen}, {31'd0, !(expG1 && bus.i_we1)});
      checkVal("memBe", {28'd0, bus.o_memBe}, expG0 ? 32'hF : (expG1 ? {28'd0, bus.i_be1} : 32'h0));
      checkVal("memAddr", {20'd0, bus.o_memAddr},
               expG0 ? {20'd0, bus.i_addr0} : (expG1 ? {20'd0, bus.i_addr1} : 32'h0));
      checkVal("memDi", bus.o_memDi, expG1 ? bus.i_wdata1 : 32'h0);
      checkVal("rvalid0", {31'd0, bus.o_rvalid0}, {31'd0, expRv0});
      checkVal("rvalid1", {31'd0, bus.o_rvalid1}, {31'd0, expRv1});
      checkVal("rdata0", bus.o_rdata0, expRd0);
      checkVal("rdata1", bus.o_rdata1, expRd1);
      checkVal("gcnt0", bus.o_gcnt0, modCnt0);
      checkVal("gcnt1", bus.o_gcnt1, modCnt1);
   endtask

   // Advance the model at the rising edge using the grants predicted for this cycle
   task automatic updateModel();
      logic [AW-1:0] a;
      if (rst) begin
         modLast = 1;
         modCnt0 = 0;
         modCnt1 = 0;
         modPend = 0;
      end else begin
         a = expG0 ? bus.i_addr0 : bus.i_addr1;
         modPend = expG0 || (expG1 && !bus.i_we1);
         modPendPort = expG1 ? 1 : 0;
         modPendData = refMem[a];
         if (expG1 && bus.i_we1) begin
            for (int b = 0; b < DW / 8; b++) begin
               if (bus.i_be1[b]) refMem[a][b*8 +: 8] = bus.i_wdata1[b*8 +: 8];
            end
         end
         if (expG0) begin
            modLast = 0;
            if (modCnt0 != 32'hFFFF_FFFF) modCnt0 = modCnt0 + 1;
         end
         if (expG1) begin
            modLast = 1;
            if (modCnt1 != 32'hFFFF_FFFF) modCnt1 = modCnt1 + 1;
         end
      end
   endtask

   // Drive one cycle of inputs, check mid-cycle, then clock the model
   task automatic applyStimulus(input bit r, input bit mode, input bit req0, input logic [AW-1:0] addr0,
                                input bit req1, input bit we1, input logic [3:0] be1,
                                input logic [AW-1:0] addr1, input logic [DW-1:0] wdata1);
      rst          = r;
      bus.i_mode   = mode;
      bus.i_req0   = req0;
      bus.i_addr0  = addr0;
      bus.i_req1   = req1;
      bus.i_we1    = we1;
      bus.i_be1    = be1;
      bus.i_addr1  = addr1;
      bus.i_wdata1 = wdata1;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      modLast = 1;
      modCnt0 = 0;
      modCnt1 = 0;
      modPend = 0;
      modPendPort = 0;
      modPendData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sram[i] = '0;
         refMem[i] = '0;
      end
      rst = 1'b1;
      bus.i_mode = 0; bus.i_req0 = 0; bus.i_addr0 = '0; bus.i_req1 = 0;
      bus.i_we1 = 0; bus.i_be1 = '0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
      @(posedge clk);
      #1;

      // Reset holds everything quiet even with both ports requesting
      $display("[TB] reset with requests pending");
      applyStimulus(1, 0, 1, 12'h001, 1, 0, 4'hF, 12'h002, 32'h0);
      applyStimulus(1, 0, 1, 12'h001, 1, 1, 4'hF, 12'h002, 32'h1234);

      // Round-robin tie: 0,1,0,1 then responses drain
      $display("[TB] round-robin tie");
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 0, 1, 12'h020 + 12'(i), 1, 0, 4'hF, 12'h040 + 12'(i), 32'h0);
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);
      checkVal("rrGcnt0", bus.o_gcnt0, 32'd2);
      checkVal("rrGcnt1", bus.o_gcnt1, 32'd2);

      // Fixed priority to port 1
      $display("[TB] fixed priority");
      applyStimulus(1, 1, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1, 1, 12'h050, 1, 0, 4'hF, 12'h060 + 12'(i), 32'h0);
      applyStimulus(0, 1, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);
      checkVal("fpGcnt1", bus.o_gcnt1, 32'd3);
      checkVal("fpGcnt0", bus.o_gcnt0, 32'd0);

      // Partial write then fetch the same word
      $display("[TB] byte-enabled write then read");
      applyStimulus(0, 0, 0, 12'h0, 1, 1, 4'b0011, 12'h010, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 1, 12'h010, 0, 0, 4'h0, 12'h0, 32'h0);
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);

      // Reset in the response cycle suppresses the read data
      $display("[TB] reset after read grant");
      applyStimulus(0, 0, 1, 12'h010, 0, 0, 4'h0, 12'h0, 32'h0);
      applyStimulus(1, 0, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);

      // Counter saturation from a preloaded value
      $display("[TB] grant counter saturation");
      force dut.r_gcnt1 = 32'hFFFF_FFFE;
      #1;
      release dut.r_gcnt1;
      modCnt1 = 32'hFFFF_FFFE;
      applyStimulus(0, 0, 0, 12'h0, 1, 0, 4'hF, 12'h003, 32'h0);
      applyStimulus(0, 0, 0, 12'h0, 1, 0, 4'hF, 12'h004, 32'h0);
      applyStimulus(0, 0, 0, 12'h0, 1, 1, 4'hF, 12'h005, 32'h0);
      checkVal("satGcnt1", bus.o_gcnt1, 32'hFFFF_FFFF);

      // Random traffic over a small address window so reads hit earlier writes
      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), 12'($urandom_range(0, 15)), $urandom);
      end
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 4'h0, 12'h0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
